// File: rtl/wb_soc_reg_slave.sv
// Wishbone register bank for a video engine: frame-buffer ADDR, irq CTRL/STATUS, and a constant ID.
// Define WB_SOC_REG_ERR_EN to terminate unmapped accesses and ID writes with ERR instead of ACK.
module wb_soc_reg_slave #(
    parameter int unsigned ADDR_W     = 8,
    parameter logic [31:0] RESET_ADDR = 32'h41000000,
    parameter logic [31:0] ID_VALUE   = 32'h56494430
) (
    input  logic        p_clk_100mhz,
    input  logic        p_reset,
    input  logic        raise_irq,
    output logic        irq,
    output logic [31:0] module_register,
    output logic        initialized,
    input  logic [31:0] p_wb_reg_DAT_I,
    output logic [31:0] p_wb_reg_DAT_O,
    input  logic [31:0] p_wb_reg_ADR_I,
    output logic        p_wb_reg_ACK_O,
    input  logic        p_wb_reg_CYC_I,
    output logic        p_wb_reg_ERR_O,
    input  logic        p_wb_reg_LOCK_I,
    output logic        p_wb_reg_RTY_O,
    input  logic [3:0]  p_wb_reg_SEL_I,
    input  logic        p_wb_reg_STB_I,
    input  logic        p_wb_reg_WE_I
);
    localparam logic [1:0] REG_ADDR   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] addr_q, addr_d;
    logic        init_q, init_d;
    logic        enable_q, enable_d;
    logic        pending_q, pending_d;
    logic        irq_q, irq_d;
    logic        raise_prev_q;

    logic        access;
    logic        mapped;
    logic        is_err;
    logic        status_clr;
    logic        raise_rise;
    logic [1:0]  word;
    logic [31:0] rd_word;
    logic [31:0] addr_merged;

    assign access = p_wb_reg_CYC_I & p_wb_reg_STB_I & ~ack_q & ~err_q;
    assign word   = p_wb_reg_ADR_I[3:2];

    // Only the first four words of the decoded window are backed by registers.
    generate
        if (ADDR_W > 4) begin : g_decode
            assign mapped = (p_wb_reg_ADR_I[ADDR_W-1:4] == '0);
        end else begin : g_decode_all
            assign mapped = 1'b1;
        end
    endgenerate

    logic unused_ok;
    assign unused_ok = &{1'b0, p_wb_reg_LOCK_I, p_wb_reg_ADR_I[31:ADDR_W], p_wb_reg_ADR_I[1:0]};

`ifdef WB_SOC_REG_ERR_EN
    assign is_err = ~mapped | (p_wb_reg_WE_I & (word == REG_ID));
`else
    assign is_err = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign addr_merged[8*gi +: 8] = p_wb_reg_SEL_I[gi] ? p_wb_reg_DAT_I[8*gi +: 8]
                                                               : addr_q[8*gi +: 8];
        end
    endgenerate

    assign raise_rise = raise_irq & ~raise_prev_q;

    always_comb begin
        rd_word = '0;
        if (mapped) begin
            case (word)
                REG_ADDR:   rd_word = addr_q;
                REG_CTRL:   rd_word = {31'd0, enable_q};
                REG_STATUS: rd_word = {31'd0, pending_q};
                default:    rd_word = ID_VALUE;
            endcase
        end
    end

    always_comb begin
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_d      = dat_q;
        addr_d     = addr_q;
        init_d     = init_q;
        enable_d   = enable_q;
        status_clr = 1'b0;
        if (access) begin
            if (is_err) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (!p_wb_reg_WE_I) begin
                    dat_d = rd_word;
                end else if (mapped) begin
                    case (word)
                        REG_ADDR: begin
                            addr_d = addr_merged;
                            init_d = init_q | (|p_wb_reg_SEL_I);
                        end
                        REG_CTRL: begin
                            if (p_wb_reg_SEL_I[0]) enable_d = p_wb_reg_DAT_I[0];
                        end
                        REG_STATUS: status_clr = p_wb_reg_SEL_I[0] & p_wb_reg_DAT_I[0];
                        default: ;
                    endcase
                end
            end
        end
        // A new edge from the engine outranks a simultaneous software clear.
        pending_d = raise_rise | (pending_q & ~status_clr);
        irq_d     = pending_q & enable_q;
    end

    always_ff @(posedge p_clk_100mhz) begin
        if (p_reset) begin
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            dat_q        <= '0;
            addr_q       <= RESET_ADDR;
            init_q       <= 1'b0;
            enable_q     <= 1'b0;
            pending_q    <= 1'b0;
            irq_q        <= 1'b0;
            raise_prev_q <= 1'b0;
        end else begin
            ack_q        <= ack_d;
            err_q        <= err_d;
            dat_q        <= dat_d;
            addr_q       <= addr_d;
            init_q       <= init_d;
            enable_q     <= enable_d;
            pending_q    <= pending_d;
            irq_q        <= irq_d;
            raise_prev_q <= raise_irq;
        end
    end

    assign p_wb_reg_ACK_O  = ack_q;
    assign p_wb_reg_ERR_O  = err_q;
    assign p_wb_reg_RTY_O  = 1'b0;
    assign p_wb_reg_DAT_O  = dat_q;
    assign module_register = addr_q;
    assign initialized     = init_q;
    assign irq             = irq_q;
endmodule

// File: tb/tb_wb_soc_reg_slave.sv
// Bench for wb_soc_reg_slave: directed vector table, hand-written corner sequences, and
// randomized bus traffic checked against a transaction-level register model.
module tb_wb_soc_reg_slave;
`ifdef WB_SOC_REG_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] RST_ADDR = 32'h41000000;
    localparam logic [31:0] ID_VAL   = 32'h56494430;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        raise = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, lock = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, dat_w = '0;
    logic        irq, initialized, ack, err, rty;
    logic [31:0] mreg, dat_r;

    wb_soc_reg_slave dut (
        .p_clk_100mhz    (clk),
        .p_reset         (rst),
        .raise_irq       (raise),
        .irq             (irq),
        .module_register (mreg),
        .initialized     (initialized),
        .p_wb_reg_DAT_I  (dat_w),
        .p_wb_reg_DAT_O  (dat_r),
        .p_wb_reg_ADR_I  (adr),
        .p_wb_reg_ACK_O  (ack),
        .p_wb_reg_CYC_I  (cyc),
        .p_wb_reg_ERR_O  (err),
        .p_wb_reg_LOCK_I (lock),
        .p_wb_reg_RTY_O  (rty),
        .p_wb_reg_SEL_I  (sel),
        .p_wb_reg_STB_I  (stb),
        .p_wb_reg_WE_I   (we)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state
    logic [31:0] m_addr = RST_ADDR;
    logic        m_en = 1'b0, m_pend = 1'b0, m_init = 1'b0, m_rprev = 1'b0;
    logic [31:0] m_dat = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = RST_ADDR; m_en = 0; m_pend = 0; m_init = 0; m_rprev = 0; m_dat = '0;
    endtask

    task automatic model_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, input logic r,
                              output logic e_ack, output logic e_err);
        logic [7:0] off;
        logic mapped, bad, rise, clr;
        off    = a[7:0] & 8'hFC;
        mapped = (off <= 8'h0C);
        bad    = ERR_EN && (!mapped || (w && off == 8'h0C));
        rise   = r && !m_rprev;
        m_rprev = r;
        clr    = 1'b0;
        e_ack  = !bad;
        e_err  = bad;
        if (!bad) begin
            if (!w) begin
                case (off)
                    8'h00:   m_dat = m_addr;
                    8'h04:   m_dat = {31'd0, m_en};
                    8'h08:   m_dat = {31'd0, m_pend};
                    8'h0C:   m_dat = ID_VAL;
                    default: m_dat = '0;
                endcase
            end else begin
                case (off)
                    8'h00: begin
                        for (int i = 0; i < 4; i++)
                            if (s[i]) m_addr[8*i +: 8] = d[8*i +: 8];
                        if (s != 4'd0) m_init = 1'b1;
                    end
                    8'h04: if (s[0]) m_en = d[0];
                    8'h08: clr = s[0] && d[0];
                    default: ;
                endcase
            end
        end
        m_pend = rise || (m_pend && !clr);
    endtask

    // Called at posedge+1; returns at posedge+1 two edges later.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic r,
                        output logic [31:0] rd, output logic ak, output logic er,
                        output logic ini);
        cyc = 1; stb = 1; we = w; adr = a; sel = s; dat_w = d; raise = r;
        @(posedge clk); #1;
        rd = dat_r; ak = ack; er = err; ini = initialized;
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        chk("term_width", {30'd0, ack, err}, 32'd0);
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic r,
                       output logic [31:0] rd, output logic ak, output logic er);
        logic ea, ee, ini;
        model_xfer(w, a, s, d, r, ea, ee);
        xfer(w, a, s, d, r, rd, ak, er, ini);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_ack;
        logic        exp_init;
        logic [31:0] exp_mreg;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] rd;
        logic ak, er, ini, ea, ee;

        vecs[0]  = '{0, 32'h00,  4'h0, 32'h0,        RST_ADDR,     1, 0, RST_ADDR};
        vecs[1]  = '{0, 32'h04,  4'h0, 32'h0,        32'h0,        1, 0, RST_ADDR};
        vecs[2]  = '{0, 32'h08,  4'h0, 32'h0,        32'h0,        1, 0, RST_ADDR};
        vecs[3]  = '{0, 32'h0C,  4'h0, 32'h0,        ID_VAL,       1, 0, RST_ADDR};
        vecs[4]  = '{1, 32'h00,  4'h3, 32'h12345678, ID_VAL,       1, 1, 32'h41005678};
        vecs[5]  = '{0, 32'h00,  4'h0, 32'h0,        32'h41005678, 1, 1, 32'h41005678};
        vecs[6]  = '{0, 32'h10,  4'h0, 32'h0,        ERR_EN ? 32'h41005678 : 32'h0,
                     !ERR_EN, 1, 32'h41005678};
        vecs[7]  = '{0, 32'h03,  4'h0, 32'h0,        32'h41005678, 1, 1, 32'h41005678};
        vecs[8]  = '{1, 32'h0C,  4'hF, 32'hFFFFFFFF, 32'h41005678, !ERR_EN, 1, 32'h41005678};
        vecs[9]  = '{0, 32'h0C,  4'h0, 32'h0,        ID_VAL,       1, 1, 32'h41005678};
        vecs[10] = '{1, 32'h100, 4'hF, 32'hAABBCCDD, ID_VAL,       1, 1, 32'hAABBCCDD};
        vecs[11] = '{0, 32'h00,  4'h0, 32'h0,        32'hAABBCCDD, 1, 1, 32'hAABBCCDD};
        vecs[12] = '{1, 32'h04,  4'h0, 32'h000000FF, 32'hAABBCCDD, 1, 1, 32'hAABBCCDD};
        vecs[13] = '{0, 32'h04,  4'h0, 32'h0,        32'h0,        1, 1, 32'hAABBCCDD};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_rty", {31'd0, rty}, 0);
        chk("rst_dat", dat_r, 0);
        chk("rst_mreg", mreg, RST_ADDR);
        chk("rst_init", {31'd0, initialized}, 0);
        chk("rst_irq", {31'd0, irq}, 0);

        for (int i = 0; i < 14; i++) begin
            model_xfer(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, 1'b0, ea, ee);
            xfer(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, 1'b0, rd, ak, er, ini);
            $display("[TB] vec %0d we=%0d adr=%h sel=%h dat=%h -> rd=%h ack=%0d err=%0d",
                     i, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, rd, ak, er);
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_ack", i), {31'd0, ak}, {31'd0, vecs[i].exp_ack});
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, !vecs[i].exp_ack});
            chk($sformatf("vec%0d_init_at_ack", i), {31'd0, ini}, {31'd0, vecs[i].exp_init});
            chk($sformatf("vec%0d_mreg", i), mreg, vecs[i].exp_mreg);
        end

        // Masked interrupt, then enable, then W1C
        txn(0, 32'h08, 4'h0, 0, 1, rd, ak, er);
        chk("irq_status_pre", rd, 0);
        txn(0, 32'h08, 4'h0, 0, 1, rd, ak, er);
        chk("irq_status_set", rd, 1);
        chk("irq_masked", {31'd0, irq}, 0);
        txn(1, 32'h04, 4'h1, 1, 0, rd, ak, er);
        chk("irq_enabled", {31'd0, irq}, 1);
        txn(1, 32'h08, 4'h1, 1, 0, rd, ak, er);
        chk("irq_w1c", {31'd0, irq}, 0);
        txn(0, 32'h08, 4'h0, 0, 0, rd, ak, er);
        chk("irq_status_clr", rd, 0);
        $display("[TB] irq sequence done");

        // W1C on the same edge as a new rising edge: set wins
        txn(1, 32'h08, 4'h1, 1, 1, rd, ak, er);
        txn(0, 32'h08, 4'h0, 0, 1, rd, ak, er);
        chk("set_wins_status", rd, 1);
        chk("set_wins_irq", {31'd0, irq}, 1);
        txn(1, 32'h08, 4'h1, 1, 0, rd, ak, er);
        chk("set_wins_clear", {31'd0, irq}, 0);
        $display("[TB] set-vs-clear sequence done");

        // Steady strobe: ACK on every second edge
        cyc = 1; stb = 1; we = 0; adr = 32'h0C; sel = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("steady_ack%0d", k), {31'd0, ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk("steady_dat", dat_r, ID_VAL);
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        chk("steady_idle", {31'd0, ack}, 0);
        m_dat = ID_VAL;
        $display("[TB] steady strobe sequence done");

        for (int t = 0; t < 200; t++) begin
            logic        w, r;
            logic [31:0] a, d;
            logic [3:0]  s;
            w = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 31));
            s = 4'($urandom);
            d = $urandom;
            r = 1'($urandom_range(0, 1));
            model_xfer(w, a, s, d, r, ea, ee);
            xfer(w, a, s, d, r, rd, ak, er, ini);
            $display("[TB] rnd %0d we=%0d adr=%h sel=%h dat=%h raise=%0d -> rd=%h ack=%0d err=%0d irq=%0d",
                     t, w, a, s, d, r, rd, ak, er, irq);
            chk("rnd_rd", rd, m_dat);
            chk("rnd_ack", {31'd0, ak}, {31'd0, ea});
            chk("rnd_err", {31'd0, er}, {31'd0, ee});
            chk("rnd_mreg", mreg, m_addr);
            chk("rnd_init", {31'd0, initialized}, {31'd0, m_init});
            chk("rnd_irq", {31'd0, irq}, {31'd0, m_pend & m_en});
        end

        // Reset asserted during the ACK cycle of an ADDR write
        raise = 0;
        cyc = 1; stb = 1; we = 1; adr = 32'h0; sel = 4'hF; dat_w = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("midrst_ack", {31'd0, ack}, 1);
        rst = 1; cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        chk("midrst_ack_drop", {31'd0, ack}, 0);
        chk("midrst_mreg", mreg, RST_ADDR);
        chk("midrst_init", {31'd0, initialized}, 0);
        chk("midrst_dat", dat_r, 0);
        rst = 0;
        model_reset();
        txn(0, 32'h00, 4'h0, 0, 0, rd, ak, er);
        chk("midrst_readback", rd, RST_ADDR);
        $display("[TB] reset mid-transfer sequence done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
